// File: rtl/cache_nway_wb_if.sv
// rtl/cache_nway_wb_if.sv - CPU-side line bus and physical-memory bus of the write-back cache
interface cache_nway_wb_if #(
    parameter int s_offset = 5
);
    localparam int s_line = 8 * 2**s_offset;

    logic [31:0]          mem_address;
    logic                 mem_read;
    logic                 mem_write;
    logic [2**s_offset-1:0] mem_byte_enable256;
    logic [s_line-1:0]    mem_wdata256;
    logic [s_line-1:0]    mem_rdata256;
    logic                 mem_resp;
    logic [31:0]          pmem_address;
    logic                 pmem_read;
    logic                 pmem_write;
    logic [s_line-1:0]    pmem_wdata;
    logic [s_line-1:0]    pmem_rdata;
    logic                 pmem_resp;

    modport slave (
        input  mem_address, mem_read, mem_write, mem_byte_enable256, mem_wdata256,
        input  pmem_rdata, pmem_resp,
        output mem_rdata256, mem_resp, pmem_address, pmem_read, pmem_write, pmem_wdata
    );

    modport master (
        output mem_address, mem_read, mem_write, mem_byte_enable256, mem_wdata256,
        output pmem_rdata, pmem_resp,
        input  mem_rdata256, mem_resp, pmem_address, pmem_read, pmem_write, pmem_wdata
    );
endinterface

// File: rtl/cache_nway_wb.sv
// rtl/cache_nway_wb.sv - N-way set-associative write-back, write-allocate cache with tree PLRU
module cache_nway_wb #(
    parameter int s_offset = 5,
    parameter int s_index  = 3,
    parameter int num_ways = 4,
    parameter int s_tag    = 32 - s_offset - s_index,
    parameter int s_line   = 8 * 2**s_offset
) (
    input  logic          clk,
    input  logic          rst,
    cache_nway_wb_if.slave bus,
    output logic [31:0]   hit_count,
    output logic [31:0]   miss_count
);
    localparam int n_sets  = 2**s_index;
    localparam int n_bytes = 2**s_offset;
    localparam int lw      = $clog2(num_ways);

    typedef enum logic [1:0] {COMPARE, WRITEBACK, FILL} state_t;
    state_t state;

    logic [s_tag-1:0]    tag_arr   [n_sets][num_ways];
    logic [s_line-1:0]   data_arr  [n_sets][num_ways];
    logic [num_ways-1:0] valid_arr [n_sets];
    logic [num_ways-1:0] dirty_arr [n_sets];
    logic [num_ways-2:0] plru_arr  [n_sets];

    logic [s_index-1:0] cur_idx, miss_idx;
    logic [s_tag-1:0]   cur_tag, miss_tag;
    logic [lw-1:0]      hit_way, inv_way, victim, victim_way;
    logic               hit, inv_found, req, write_hit, miss_pending;
    logic [s_line-1:0]  hit_line, merged;
    logic               unused_offset;

    // Heap-ordered tree: node n has children 2n and 2n+1; bit 0 steers the victim to the lower half.
    function automatic logic [lw-1:0] plru_victim(input logic [num_ways-2:0] bits);
        int node;
        node = 1;
        for (int l = 0; l < lw; l++) node = 2 * node + int'(bits[node-1]);
        return lw'(node - num_ways);
    endfunction

    function automatic logic [num_ways-2:0] plru_touch(input logic [num_ways-2:0] bits,
                                                       input logic [lw-1:0] way);
        int node;
        logic [num_ways-2:0] r;
        r = bits;
        node = 1;
        for (int l = 0; l < lw; l++) begin
            r[node-1] = ~way[lw-1-l];
            node = 2 * node + int'(way[lw-1-l]);
        end
        return r;
    endfunction

    assign cur_idx       = bus.mem_address[s_offset+s_index-1 -: s_index];
    assign cur_tag       = bus.mem_address[31 -: s_tag];
    assign unused_offset = ^bus.mem_address[s_offset-1:0];
    assign req           = bus.mem_read | bus.mem_write;

    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = 0; w < num_ways; w++) begin
            if (valid_arr[cur_idx][w] && tag_arr[cur_idx][w] == cur_tag) begin
                hit     = 1'b1;
                hit_way = lw'(w);
            end
        end
        for (int w = num_ways - 1; w >= 0; w--) begin
            if (!valid_arr[cur_idx][w]) begin
                inv_found = 1'b1;
                inv_way   = lw'(w);
            end
        end
        victim   = inv_found ? inv_way : plru_victim(plru_arr[cur_idx]);
        hit_line = data_arr[cur_idx][hit_way];
        merged   = hit_line;
        for (int b = 0; b < n_bytes; b++)
            if (bus.mem_byte_enable256[b]) merged[8*b +: 8] = bus.mem_wdata256[8*b +: 8];
    end

    assign bus.mem_resp     = (state == COMPARE) && req && hit;
    assign bus.mem_rdata256 = (bus.mem_resp && bus.mem_read) ? hit_line : '0;
    assign write_hit        = bus.mem_resp && !bus.mem_read;

    // Tag and line contents carry no reset; valid bits gate every use of them.
    always_ff @(posedge clk) begin
        if (write_hit) begin
            data_arr[cur_idx][hit_way] <= merged;
        end else if (state == FILL && bus.pmem_resp) begin
            data_arr[miss_idx][victim_way] <= bus.pmem_rdata;
            tag_arr[miss_idx][victim_way]  <= miss_tag;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= COMPARE;
            bus.pmem_read    <= 1'b0;
            bus.pmem_write   <= 1'b0;
            bus.pmem_address <= '0;
            bus.pmem_wdata   <= '0;
            victim_way       <= '0;
            miss_idx         <= '0;
            miss_tag         <= '0;
            miss_pending     <= 1'b0;
            hit_count        <= '0;
            miss_count       <= '0;
            for (int s = 0; s < n_sets; s++) begin
                valid_arr[s] <= '0;
                dirty_arr[s] <= '0;
                plru_arr[s]  <= '0;
            end
        end else begin
            case (state)
                COMPARE: begin
                    if (!req) begin
                        miss_pending <= 1'b0;
                    end else if (hit) begin
                        plru_arr[cur_idx] <= plru_touch(plru_arr[cur_idx], hit_way);
                        if (write_hit) dirty_arr[cur_idx][hit_way] <= 1'b1;
                        if (miss_pending) miss_pending <= 1'b0;
                        else if (hit_count != '1) hit_count <= hit_count + 32'd1;
                    end else begin
                        if (miss_count != '1) miss_count <= miss_count + 32'd1;
                        miss_pending <= 1'b1;
                        victim_way   <= victim;
                        miss_idx     <= cur_idx;
                        miss_tag     <= cur_tag;
                        if (valid_arr[cur_idx][victim] && dirty_arr[cur_idx][victim]) begin
                            bus.pmem_write   <= 1'b1;
                            bus.pmem_address <= {tag_arr[cur_idx][victim], cur_idx, {s_offset{1'b0}}};
                            bus.pmem_wdata   <= data_arr[cur_idx][victim];
                            state            <= WRITEBACK;
                        end else begin
                            bus.pmem_read    <= 1'b1;
                            bus.pmem_address <= {cur_tag, cur_idx, {s_offset{1'b0}}};
                            state            <= FILL;
                        end
                    end
                end
                WRITEBACK: begin
                    if (bus.pmem_resp) begin
                        bus.pmem_write   <= 1'b0;
                        bus.pmem_read    <= 1'b1;
                        bus.pmem_address <= {miss_tag, miss_idx, {s_offset{1'b0}}};
                        state            <= FILL;
                    end
                end
                FILL: begin
                    if (bus.pmem_resp) begin
                        bus.pmem_read                  <= 1'b0;
                        valid_arr[miss_idx][victim_way] <= 1'b1;
                        dirty_arr[miss_idx][victim_way] <= 1'b0;
                        plru_arr[miss_idx]             <= plru_touch(plru_arr[miss_idx], victim_way);
                        state                          <= COMPARE;
                    end
                end
                default: state <= COMPARE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_nway_wb.sv
// tb/tb_cache_nway_wb.sv - directed self-checking bench for cache_nway_wb
module tb_cache_nway_wb;
    logic        clk;
    logic        rst;
    logic [31:0] hit_count, miss_count;
    int          tests, fails;

    cache_nway_wb_if bus ();

    cache_nway_wb dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [255:0] line_a   = {8{32'h1111_1111}};
    localparam logic [255:0] line_b   = {8{32'h2222_2222}};
    localparam logic [255:0] line_c   = {8{32'h3333_3333}};
    localparam logic [255:0] line_d   = {8{32'h4444_4444}};
    localparam logic [255:0] line_e   = {8{32'h5555_5555}};
    localparam logic [255:0] line_f   = {8{32'h6666_6666}};
    localparam logic [255:0] line_g   = {8{32'h7777_7777}};
    localparam logic [255:0] a_merged = {{7{32'h1111_1111}}, 32'hAABB_CCDD};

    task automatic start_req(input logic r, input logic w, input logic [31:0] a,
                             input logic [31:0] be, input logic [255:0] wd);
        @(posedge clk); #1;
        bus.mem_address        = a;
        bus.mem_read           = r;
        bus.mem_write          = w;
        bus.mem_byte_enable256 = be;
        bus.mem_wdata256       = wd;
    endtask

    task automatic end_req;
        @(posedge clk); #1;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
    endtask

    task automatic wait_pmem(output logic got, output logic rd, output logic wr,
                             output logic [31:0] a, output logic [255:0] wd);
        got = 1'b0; rd = 1'b0; wr = 1'b0; a = '0; wd = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.pmem_read || bus.pmem_write) begin
                got = 1'b1; rd = bus.pmem_read; wr = bus.pmem_write;
                a = bus.pmem_address; wd = bus.pmem_wdata;
                break;
            end
        end
    endtask

    task automatic pulse_resp(input logic [255:0] d);
        bus.pmem_rdata = d;
        bus.pmem_resp  = 1'b1;
        @(posedge clk); #1;
        bus.pmem_resp  = 1'b0;
    endtask

    task automatic wait_resp(output logic got, output int cyc, output logic [255:0] rd);
        got = 1'b0; cyc = 0; rd = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.mem_resp) begin
                got = 1'b1; rd = bus.mem_rdata256;
                break;
            end
            cyc++;
        end
    endtask

    task automatic hit_read(input logic [31:0] a, output logic got, output int cyc,
                            output logic [255:0] rd);
        start_req(1'b1, 1'b0, a, '0, '0);
        wait_resp(got, cyc, rd);
        end_req();
    endtask

    task automatic miss_fill(input logic [31:0] a, input logic [255:0] line,
                             output logic [31:0] pa, output logic ok);
        logic g, r, w, gr;
        logic [255:0] wd, rd;
        int cyc;
        start_req(1'b1, 1'b0, a, '0, '0);
        wait_pmem(g, r, w, pa, wd);
        if (g) pulse_resp(line);
        wait_resp(gr, cyc, rd);
        end_req();
        ok = g && r && !w && gr && (cyc == 0) && (rd === line);
    endtask

    task automatic test_reset;
        bus.mem_address = '0; bus.mem_read = 1'b0; bus.mem_write = 1'b0;
        bus.mem_byte_enable256 = '0; bus.mem_wdata256 = '0;
        bus.pmem_rdata = '0; bus.pmem_resp = 1'b0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++; if (bus.pmem_read !== 1'b0) begin fails++; $display("FAIL reset_pmem_read got %b want 0", bus.pmem_read); end
        tests++; if (bus.pmem_write !== 1'b0) begin fails++; $display("FAIL reset_pmem_write got %b want 0", bus.pmem_write); end
        tests++; if (bus.mem_resp !== 1'b0) begin fails++; $display("FAIL reset_mem_resp got %b want 0", bus.mem_resp); end
        tests++; if (hit_count !== 32'd0 || miss_count !== 32'd0) begin fails++; $display("FAIL reset_counters got %0d/%0d want 0/0", hit_count, miss_count); end
        tests++; if (bus.mem_rdata256 !== '0) begin fails++; $display("FAIL reset_rdata got %h want 0", bus.mem_rdata256); end
        tests++; if (bus.pmem_wdata !== '0) begin fails++; $display("FAIL reset_pmem_wdata got %h want 0", bus.pmem_wdata); end
        @(posedge clk); #1 rst = 1'b1;
    endtask

    task automatic test_read_miss;
        logic g, r, w, gr;
        logic [31:0] pa;
        logic [255:0] wd, rd;
        int cyc;
        start_req(1'b1, 1'b0, 32'h0000_0040, '0, '0);
        @(negedge clk);
        tests++; if (bus.mem_resp !== 1'b0) begin fails++; $display("FAIL miss_no_early_resp got %b want 0", bus.mem_resp); end
        wait_pmem(g, r, w, pa, wd);
        tests++; if (!(g && r && !w)) begin fails++; $display("FAIL miss_fill_req got rd=%b wr=%b want rd=1 wr=0", r, w); end
        tests++; if (pa !== 32'h0000_0040) begin fails++; $display("FAIL miss_fill_addr got %h want 00000040", pa); end
        if (g) pulse_resp(line_a);
        wait_resp(gr, cyc, rd);
        tests++; if (!gr || cyc != 0) begin fails++; $display("FAIL miss_resp_latency got resp=%b cyc=%0d want 1/0", gr, cyc); end
        tests++; if (rd !== line_a) begin fails++; $display("FAIL miss_rdata got %h want %h", rd, line_a); end
        end_req();
        tests++; if (miss_count !== 32'd1 || hit_count !== 32'd0) begin fails++; $display("FAIL miss_counters got %0d/%0d want 0/1", hit_count, miss_count); end
    endtask

    task automatic test_read_hit;
        logic gr;
        logic [255:0] rd;
        int cyc;
        start_req(1'b1, 1'b0, 32'h0000_0040, '0, '0);
        wait_resp(gr, cyc, rd);
        tests++; if (bus.pmem_read !== 1'b0 || bus.pmem_write !== 1'b0) begin fails++; $display("FAIL hit_pmem_idle got rd=%b wr=%b want 0/0", bus.pmem_read, bus.pmem_write); end
        end_req();
        tests++; if (!gr || cyc != 0) begin fails++; $display("FAIL hit_same_cycle got resp=%b cyc=%0d want 1/0", gr, cyc); end
        tests++; if (rd !== line_a) begin fails++; $display("FAIL hit_rdata got %h want %h", rd, line_a); end
        tests++; if (hit_count !== 32'd1 || miss_count !== 32'd1) begin fails++; $display("FAIL hit_counters got %0d/%0d want 1/1", hit_count, miss_count); end
    endtask

    task automatic test_write_merge;
        logic gr;
        logic [255:0] rd;
        int cyc;
        start_req(1'b0, 1'b1, 32'h0000_0040, 32'h0000_000F, {8{32'hAABB_CCDD}});
        wait_resp(gr, cyc, rd);
        end_req();
        tests++; if (!gr || cyc != 0) begin fails++; $display("FAIL write_hit_resp got resp=%b cyc=%0d want 1/0", gr, cyc); end
        hit_read(32'h0000_0040, gr, cyc, rd);
        tests++; if (rd !== a_merged) begin fails++; $display("FAIL write_merge got %h want %h", rd, a_merged); end
        tests++; if (hit_count !== 32'd3) begin fails++; $display("FAIL write_hit_count got %0d want 3", hit_count); end
    endtask

    task automatic test_plru;
        logic ok, g, r, w, gr;
        logic [31:0] pa;
        logic [255:0] wd, rd;
        int cyc;
        miss_fill(32'h0000_0140, line_b, pa, ok);
        tests++; if (!ok || pa !== 32'h0000_0140) begin fails++; $display("FAIL plru_fill_b got ok=%b addr=%h want 1/00000140", ok, pa); end
        miss_fill(32'h0000_0240, line_c, pa, ok);
        tests++; if (!ok || pa !== 32'h0000_0240) begin fails++; $display("FAIL plru_fill_c got ok=%b addr=%h want 1/00000240", ok, pa); end
        miss_fill(32'h0000_0340, line_d, pa, ok);
        tests++; if (!ok || pa !== 32'h0000_0340) begin fails++; $display("FAIL plru_fill_d got ok=%b addr=%h want 1/00000340", ok, pa); end
        hit_read(32'h0000_0040, gr, cyc, rd);
        tests++; if (!gr || cyc != 0 || rd !== a_merged) begin fails++; $display("FAIL plru_touch_a got resp=%b cyc=%0d data=%h", gr, cyc, rd); end
        start_req(1'b1, 1'b0, 32'h0000_0440, '0, '0);
        wait_pmem(g, r, w, pa, wd);
        tests++; if (!(g && r && !w) || pa !== 32'h0000_0440) begin fails++; $display("FAIL plru_victim_c_clean got rd=%b wr=%b addr=%h want 1/0/00000440", r, w, pa); end
        if (g) pulse_resp(line_e);
        wait_resp(gr, cyc, rd);
        end_req();
        tests++; if (!gr || rd !== line_e) begin fails++; $display("FAIL plru_e_data got resp=%b data=%h want %h", gr, rd, line_e); end
        hit_read(32'h0000_0040, gr, cyc, rd);
        tests++; if (!gr || cyc != 0 || rd !== a_merged) begin fails++; $display("FAIL plru_a_kept got resp=%b cyc=%0d data=%h", gr, cyc, rd); end
    endtask

    task automatic test_dirty_evict;
        logic g, r, w, gr;
        logic [31:0] pa;
        logic [255:0] wd, rd;
        int cyc;
        hit_read(32'h0000_0140, gr, cyc, rd);
        tests++; if (!gr || cyc != 0 || rd !== line_b) begin fails++; $display("FAIL evict_hit_b got resp=%b cyc=%0d data=%h", gr, cyc, rd); end
        hit_read(32'h0000_0340, gr, cyc, rd);
        tests++; if (!gr || cyc != 0 || rd !== line_d) begin fails++; $display("FAIL evict_hit_d got resp=%b cyc=%0d data=%h", gr, cyc, rd); end
        start_req(1'b1, 1'b0, 32'h0000_0540, '0, '0);
        wait_pmem(g, r, w, pa, wd);
        tests++; if (!(g && w && !r) || pa !== 32'h0000_0040) begin fails++; $display("FAIL evict_wb_req got rd=%b wr=%b addr=%h want 0/1/00000040", r, w, pa); end
        tests++; if (wd !== a_merged) begin fails++; $display("FAIL evict_wb_data got %h want %h", wd, a_merged); end
        if (g) pulse_resp('0);
        wait_pmem(g, r, w, pa, wd);
        tests++; if (!(g && r && !w) || pa !== 32'h0000_0540) begin fails++; $display("FAIL evict_fill_req got rd=%b wr=%b addr=%h want 1/0/00000540", r, w, pa); end
        if (g) pulse_resp(line_f);
        wait_resp(gr, cyc, rd);
        end_req();
        tests++; if (!gr || cyc != 0 || rd !== line_f) begin fails++; $display("FAIL evict_f_data got resp=%b cyc=%0d data=%h", gr, cyc, rd); end
        tests++; if (hit_count !== 32'd7 || miss_count !== 32'd6) begin fails++; $display("FAIL evict_counters got %0d/%0d want 7/6", hit_count, miss_count); end
    endtask

    task automatic test_reset_mid_fill;
        logic g, r, w, gr;
        logic [31:0] pa;
        logic [255:0] wd, rd;
        int cyc;
        start_req(1'b1, 1'b0, 32'h0000_0640, '0, '0);
        wait_pmem(g, r, w, pa, wd);
        tests++; if (!(g && r) || pa !== 32'h0000_0640) begin fails++; $display("FAIL rstfill_req got rd=%b addr=%h want 1/00000640", r, pa); end
        bus.mem_read = 1'b0;
        rst = 1'b0;
        #1;
        tests++; if (bus.pmem_read !== 1'b0 || miss_count !== 32'd0) begin fails++; $display("FAIL rstfill_async got rd=%b miss=%0d want 0/0", bus.pmem_read, miss_count); end
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        pulse_resp(line_a);
        @(negedge clk);
        tests++; if (bus.mem_resp !== 1'b0 || bus.pmem_read !== 1'b0) begin fails++; $display("FAIL rstfill_stray_resp got resp=%b rd=%b want 0/0", bus.mem_resp, bus.pmem_read); end
        start_req(1'b1, 1'b0, 32'h0000_0640, '0, '0);
        @(negedge clk);
        tests++; if (bus.mem_resp !== 1'b0) begin fails++; $display("FAIL rstfill_remiss got resp=%b want 0", bus.mem_resp); end
        wait_pmem(g, r, w, pa, wd);
        tests++; if (!(g && r && !w) || pa !== 32'h0000_0640) begin fails++; $display("FAIL rstfill_refill got rd=%b wr=%b addr=%h want 1/0/00000640", r, w, pa); end
        if (g) pulse_resp(line_g);
        wait_resp(gr, cyc, rd);
        end_req();
        tests++; if (!gr || rd !== line_g || miss_count !== 32'd1) begin fails++; $display("FAIL rstfill_done got resp=%b data=%h miss=%0d want 1/%h/1", gr, rd, miss_count, line_g); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_read_miss();
        test_read_hit();
        test_write_merge();
        test_plru();
        test_dirty_evict();
        test_reset_mid_fill();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
